bus_uart_tx: RTL

BUS_UART_TX -- requirements
Module: bus_uart_tx

---
 rtl/bus_uart_tx.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped UART transmitter with a byte FIFO.
// A bus write to BASE_ADDR queues a byte. The FSM sends each byte as 8N1,
// LSB first, with DIV = CLK_HZ / BAUD clock cycles per bit.
// Define BUS_UART_STATUS_EN to enable the status register at BASE_ADDR+8.
// It returns {overflow, fifo_full, tx_busy}, and reading it clears overflow.
// When the macro is undefined, bus_read_data is tied to zero.
module bus_uart_tx #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_address,
  input  logic [63:0] bus_write_data,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  output logic [63:0] bus_read_data,
  output logic        uart_tx,
  output logic        tx_busy,
  output logic        fifo_full
);

  localparam int unsigned DIV        = CLK_HZ / BAUD;
  localparam int unsigned CNT_W      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(DIV - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL_CNT = FCNT_W'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  baudCnt_q, baudCnt_d;
  logic [2:0]        bitCnt_q, bitCnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              uartTx_q, uartTx_d;
  logic              busyTail_q;
  logic              overflow_q, overflow_d;
  logic [7:0]        fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
  logic [FCNT_W-1:0] fifoCnt_q, fifoCnt_d;

  logic       pushReq;
  logic       push;
  logic       pop;
  logic       drop;
  logic       fifoEmpty;
  logic       fifoFullInt;
  logic [7:0] fifoHead;

  assign pushReq     = bus_write_enable && (bus_address == BASE_ADDR);
  assign fifoEmpty   = (fifoCnt_q == '0);
  assign fifoFullInt = (fifoCnt_q == FIFO_FULL_CNT);
  assign fifoHead    = fifoMem_q[rdPtr_q];

  // A full FIFO still accepts a byte if the head leaves in the same cycle.
  assign push = pushReq && (!fifoFullInt || pop);
  assign drop = pushReq && fifoFullInt && !pop;

  // FSM: pops a byte, times start/data/stop bits with the baud counter,
  // and chains frames back to back while bytes are waiting.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop       = 1'b1;
          shift_d   = fifoHead;
          baudCnt_d = BAUD_RELOAD;
          bitCnt_d  = 3'd0;
          state_d   = START;
        end
      end
      START: begin
        if (baudCnt_q == '0) begin
          baudCnt_d = BAUD_RELOAD;
          bitCnt_d  = 3'd0;
          state_d   = DATA;
        end else begin
          baudCnt_d = baudCnt_q - 1'b1;
        end
      end
      DATA: begin
        if (baudCnt_q == '0) begin
          baudCnt_d = BAUD_RELOAD;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bitCnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end else begin
          baudCnt_d = baudCnt_q - 1'b1;
        end
      end
      STOP: begin
        if (baudCnt_q == '0) begin
          if (!fifoEmpty) begin
            pop       = 1'b1;
            shift_d   = fifoHead;
            baudCnt_d = BAUD_RELOAD;
            bitCnt_d  = 3'd0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baudCnt_d = baudCnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level for the current state; it is registered one cycle later.
  always_comb begin
    uartTx_d = 1'b1;
    if (state_q == START) begin
      uartTx_d = 1'b0;
    end else if (state_q == DATA) begin
      uartTx_d = shift_q[0];
    end
  end

  // FIFO occupancy changes only when exactly one of push/pop happens.
  always_comb begin
    fifoCnt_d = fifoCnt_q;
    case ({push, pop})
      2'b10:   fifoCnt_d = fifoCnt_q + 1'b1;
      2'b01:   fifoCnt_d = fifoCnt_q - 1'b1;
      default: fifoCnt_d = fifoCnt_q;
    endcase
  end

`ifdef BUS_UART_STATUS_EN
  logic statusRead;
  logic unusedBits;

  assign statusRead = bus_read_enable && (bus_address == BASE_ADDR + 64'd8);
  assign unusedBits = ^bus_write_data[63:8];

  // Status register read. A dropped byte in the same cycle wins over the clear.
  always_comb begin
    bus_read_data = '0;
    overflow_d    = overflow_q;
    if (statusRead) begin
      bus_read_data = {61'b0, overflow_q, fifoFullInt, tx_busy};
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (statusRead) begin
      overflow_d = 1'b0;
    end
  end
`else
  logic unusedBits;

  assign unusedBits = ^{bus_write_data[63:8], bus_read_enable, overflow_q};

  // Without the status register the bus reads zero and overflow only accumulates.
  always_comb begin
    bus_read_data = '0;
    overflow_d    = overflow_q | drop;
  end
`endif

  // FIFO storage. It needs no reset because the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= bus_write_data[7:0];
    end
  end

  // State registers. Reset aborts any frame in flight and empties the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baudCnt_q  <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      uartTx_q   <= 1'b1;
      busyTail_q <= 1'b0;
      overflow_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      fifoCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      baudCnt_q  <= baudCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      uartTx_q   <= uartTx_d;
      busyTail_q <= (state_q != IDLE);
      overflow_q <= overflow_d;
      fifoCnt_q  <= fifoCnt_d;
      if (push) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
    end
  end

  // busyTail_q keeps busy asserted while the registered stop bit is still on the line.
  assign uart_tx   = uartTx_q;
  assign tx_busy   = !fifoEmpty || (state_q != IDLE) || busyTail_q;
  assign fifo_full = fifoFullInt;

endmodule
